// File: rtl/ui_message_ctrl.sv
// Camera-UI overlay message controller: tracks export progress and selects the
// overlay message, updating the displayed tuple only on vsync frame boundaries.
module ui_message_ctrl #(
  parameter int MESSAGE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       camera_detected,
  input  logic       export_start,
  input  logic       export_done,
  input  logic       export_fail,
  input  logic [6:0] save_index,
  output logic [2:0] string_index,
  output logic [7:0] save_index_bcd,
  output logic       ui_visible,
  output logic       busy
);

  localparam int CNT_W = ($clog2(MESSAGE_FRAMES) > 8) ? $clog2(MESSAGE_FRAMES) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MESSAGE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPORTING,
    S_CONVERT,
    S_SHOW_SAVED,
    S_SHOW_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [14:0]      dd_q, dd_d;        // {tens, ones, remaining binary bits}
  logic [2:0]       step_q, step_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [2:0]       string_index_q, string_index_d;
  logic [7:0]       save_index_bcd_q, save_index_bcd_d;
  logic             ui_visible_q, ui_visible_d;
  logic             frame_edge;

  // One double-dabble iteration: bias BCD digits >= 5 by 3, then shift left.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  assign frame_edge = vsync & ~vsync_q;
  assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign busy       = (state_q != S_IDLE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dd_d    = dd_q;
    step_d  = step_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      S_IDLE: begin
        if (export_start) state_d = S_EXPORTING;
      end
      S_EXPORTING: begin
        if (export_fail) begin
          state_d = S_SHOW_FAIL;
          cnt_d   = '0;
        end else if (export_done) begin
          state_d = S_CONVERT;
          dd_d    = {8'h00, (save_index > 7'd99) ? 7'd99 : save_index};
          step_d  = '0;
        end
      end
      S_CONVERT: begin
        if (step_q != 3'd7) begin
          dd_d   = dd_step(dd_q);
          step_d = step_q + 3'd1;
        end else begin
          bcd_d   = dd_q[14:7];
          state_d = S_SHOW_SAVED;
          cnt_d   = '0;
        end
      end
      S_SHOW_SAVED, S_SHOW_FAIL: begin
        if (export_start) begin
          state_d = S_EXPORTING;
          cnt_d   = '0;
        end else if (frame_edge) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display tuple is sampled only at frame boundaries so it never tears mid-frame.
  always_comb begin
    string_index_d   = string_index_q;
    save_index_bcd_d = save_index_bcd_q;
    ui_visible_d     = ui_visible_q;
    if (frame_edge) begin
      unique case (state_q)
        S_EXPORTING, S_CONVERT: begin
          string_index_d = 3'd1;
          ui_visible_d   = 1'b1;
        end
        S_SHOW_SAVED: begin
          string_index_d   = 3'd2;
          save_index_bcd_d = bcd_q;
          ui_visible_d     = 1'b1;
        end
        S_SHOW_FAIL: begin
          string_index_d = 3'd3;
          ui_visible_d   = 1'b1;
        end
        default: begin
          if (!camera_detected) begin
            string_index_d = 3'd0;
            ui_visible_d   = 1'b1;
          end else begin
            ui_visible_d = 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; all flops, including
  // the conversion datapath, are reset so no stale export survives a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      vsync_q          <= 1'b0;
      cnt_q            <= '0;
      dd_q             <= '0;
      step_q           <= '0;
      bcd_q            <= 8'h00;
      string_index_q   <= 3'd0;
      save_index_bcd_q <= 8'h00;
      ui_visible_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      vsync_q          <= vsync;
      cnt_q            <= cnt_d;
      dd_q             <= dd_d;
      step_q           <= step_d;
      bcd_q            <= bcd_d;
      string_index_q   <= string_index_d;
      save_index_bcd_q <= save_index_bcd_d;
      ui_visible_q     <= ui_visible_d;
    end
  end

  assign string_index   = string_index_q;
  assign save_index_bcd = save_index_bcd_q;
  assign ui_visible     = ui_visible_q;

endmodule

// File: tb/tb_ui_message_ctrl.sv
// Self-checking bench for ui_message_ctrl: directed scenarios plus random
// exports, compared every clock against a behavioural message-timeline model.
module tb_ui_message_ctrl;

  localparam int N = 120;

  logic       clk;
  logic       reset_n;
  logic       vsync;
  logic       camera_detected;
  logic       export_start;
  logic       export_done;
  logic       export_fail;
  logic [6:0] save_index;
  logic [2:0] string_index;
  logic [7:0] save_index_bcd;
  logic       ui_visible;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ui_message_ctrl #(.MESSAGE_FRAMES(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .vsync           (vsync),
    .camera_detected (camera_detected),
    .export_start    (export_start),
    .export_done     (export_done),
    .export_fail     (export_fail),
    .save_index      (save_index),
    .string_index    (string_index),
    .save_index_bcd  (save_index_bcd),
    .ui_visible      (ui_visible),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: message phase plus countdowns of clocks and frames.
  localparam int PH_IDLE = 0, PH_EXPORT = 1, PH_CONV = 2, PH_SAVED = 3, PH_FAIL = 4;
  int       m_phase;
  int       m_conv_left;
  int       m_frames_left;
  bit       m_vprev;
  logic [2:0] m_si;
  logic [7:0] m_bcd;
  logic [7:0] m_saved;
  logic [7:0] m_pend;
  bit       m_vis;

  function automatic logic [7:0] to_bcd(input int v);
    int c;
    c = (v > 99) ? 99 : v;
    return 8'((c / 10) * 16 + (c % 10));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_conv_left = 0;
    m_frames_left = 0;
    m_vprev = 1'b0;
    m_si = 3'd0;
    m_bcd = 8'h00;
    m_vis = 1'b0;
  endtask

  task automatic model_clock();
    bit edge_seen;
    edge_seen = vsync && !m_vprev;
    if (edge_seen) begin
      case (m_phase)
        PH_EXPORT, PH_CONV: begin m_si = 3'd1; m_vis = 1'b1; end
        PH_SAVED: begin m_si = 3'd2; m_bcd = m_saved; m_vis = 1'b1; end
        PH_FAIL:  begin m_si = 3'd3; m_vis = 1'b1; end
        default:  begin
          if (!camera_detected) begin m_si = 3'd0; m_vis = 1'b1; end
          else m_vis = 1'b0;
        end
      endcase
    end
    case (m_phase)
      PH_IDLE: if (export_start) m_phase = PH_EXPORT;
      PH_EXPORT: begin
        if (export_fail) begin
          m_phase = PH_FAIL;
          m_frames_left = N - 1;
        end else if (export_done) begin
          m_phase = PH_CONV;
          m_conv_left = 8;
          m_pend = to_bcd(int'(save_index));
        end
      end
      PH_CONV: begin
        m_conv_left--;
        if (m_conv_left == 0) begin
          m_phase = PH_SAVED;
          m_saved = m_pend;
          m_frames_left = N - 1;
        end
      end
      default: begin
        if (export_start) m_phase = PH_EXPORT;
        else if (edge_seen) begin
          m_frames_left--;
          if (m_frames_left <= 0) m_phase = PH_IDLE;
        end
      end
    endcase
    m_vprev = vsync;
  endtask

  task automatic compare_all();
    check("string_index", 8'(string_index), 8'(m_si));
    check("save_index_bcd", save_index_bcd, m_bcd);
    check("ui_visible", 8'(ui_visible), 8'(m_vis));
    check("busy", 8'(busy), 8'(m_phase != PH_IDLE));
  endtask

  // One clock: model sees the same inputs as the DUT, outputs compared #1 later.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clock();
    #1;
    compare_all();
    export_start = 1'b0;
    export_done  = 1'b0;
    export_fail  = 1'b0;
  endtask

  task automatic frame(input int hi_cycles = 1);
    vsync = 1'b1;
    repeat (hi_cycles) tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Export that completes with value v, through to the first SHOW_SAVED frame.
  task automatic do_save(input logic [6:0] v, input logic [7:0] exp_bcd, input string tag);
    export_start = 1'b1;
    tick();
    export_done = 1'b1;
    save_index  = v;
    tick();
    repeat (8) tick();
    frame();
    check({tag, "_si"}, 8'(string_index), 8'd2);
    check({tag, "_bcd"}, save_index_bcd, exp_bcd);
  endtask

  initial begin
    reset_n = 1'b0;
    vsync = 1'b0;
    camera_detected = 1'b0;
    export_start = 1'b0;
    export_done = 1'b0;
    export_fail = 1'b0;
    save_index = 7'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Camera absent: nothing changes until the first vsync rise.
    repeat (3) tick();
    check("pre_edge_vis", 8'(ui_visible), 8'd0);
    frame(3);
    check("nocam_si", 8'(string_index), 8'd0);
    check("nocam_vis", 8'(ui_visible), 8'd1);
    check("nocam_bcd", save_index_bcd, 8'h00);

    // Save 47 and let the message run out with the camera present.
    camera_detected = 1'b1;
    export_start = 1'b1;
    tick();
    check("busy_exporting", 8'(busy), 8'd1);
    export_done = 1'b1;
    save_index = 7'd47;
    tick();
    repeat (8) tick();
    frame();
    check("save47_si", 8'(string_index), 8'd2);
    check("save47_bcd", save_index_bcd, 8'h47);
    frames(N - 2);
    check("save47_busy_last", 8'(busy), 8'd0);
    frame();
    check("save47_end_vis", 8'(ui_visible), 8'd0);
    check("save47_end_busy", 8'(busy), 8'd0);

    // Clamp and single-digit conversions, chained through restarts.
    do_save(7'd120, 8'h99, "clamp120");
    do_save(7'd0, 8'h00, "zero");
    do_save(7'd9, 8'h09, "nine");

    // Done and fail together: fail wins, BCD held.
    export_start = 1'b1;
    tick();
    export_done = 1'b1;
    export_fail = 1'b1;
    save_index = 7'd88;
    tick();
    frame();
    check("fail_si", 8'(string_index), 8'd3);
    check("fail_bcd", save_index_bcd, 8'h09);

    // Restart at frame 50 of a saved message; the new message gets a full run.
    do_save(7'd63, 8'h63, "s63");
    frames(49);
    export_start = 1'b1;
    tick();
    frame();
    check("restart_si", 8'(string_index), 8'd1);
    export_done = 1'b1;
    save_index = 7'd21;
    tick();
    repeat (8) tick();
    frames(N - 2);
    check("restart_busy_held", 8'(busy), 8'd1);
    frame();
    check("restart_busy_end", 8'(busy), 8'd0);

    // Reset during CONVERT, then a stray export_done is ignored.
    export_start = 1'b1;
    tick();
    export_done = 1'b1;
    save_index = 7'd55;
    tick();
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_si", 8'(string_index), 8'd0);
    check("rst_bcd", save_index_bcd, 8'h00);
    check("rst_vis", 8'(ui_visible), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    export_done = 1'b1;
    save_index = 7'd33;
    tick();
    repeat (10) tick();
    check("stray_done_busy", 8'(busy), 8'd0);
    frame();

    // Random exports with random camera level, outcomes and restarts.
    for (int k = 0; k < 4; k++) begin
      camera_detected = 1'($urandom_range(0, 1));
      export_start = 1'b1;
      tick();
      repeat ($urandom_range(0, 3)) frame($urandom_range(1, 3));
      save_index = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) export_fail = 1'b1;
      else export_done = 1'b1;
      tick();
      for (int f = 0; f < N + 2; f++) begin
        if ($urandom_range(0, 7) == 0) export_done = 1'b1;
        frame($urandom_range(1, 2));
        if (f == 30 && k == 1) begin
          export_start = 1'b1;
          tick();
          export_done = 1'b1;
          save_index = 7'($urandom_range(0, 127));
          tick();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ui_message_ctrl.md
UI_MESSAGE_CTRL -- requirements
Module: ui_message_ctrl

Interface
REQ-001 SHALL have parameter MESSAGE_FRAMES, default 120, number of frames a result message stays visible.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port vsync  input  1  synchronous to clk; a rising edge marks a frame boundary.
REQ-005 SHALL have port camera_detected  input  1  level; high when the camera responds.
REQ-006 SHALL have port export_start  input  1  single-cycle pulse; an SRAM export has begun.
REQ-007 SHALL have port export_done  input  1  single-cycle pulse; the export succeeded.
REQ-008 SHALL have port export_fail  input  1  single-cycle pulse; the export failed because no slots were free.
REQ-009 SHALL have port save_index  input  7  binary slot number, sampled on export_done.
REQ-010 SHALL have port string_index  output  3  message select for the overlay: 0 not detected, 1 exporting, 2 saved, 3 fail.
REQ-011 SHALL have port save_index_bcd  output  8  two BCD digits, tens in [7:4].
REQ-012 SHALL have port ui_visible  output  1  overlay enable.
REQ-013 SHALL have port busy  output  1  high while the state is not IDLE.

Function
REQ-014 SHALL implement internal states IDLE, EXPORTING, CONVERT, SHOW_SAVED and SHOW_FAIL.
REQ-015 SHALL detect a frame edge as vsync sampled 1 on the current clock and 0 on the previous one, registered internally.
REQ-016 SHALL compute a next-display tuple {string_index, save_index_bcd, ui_visible} combinationally from state:
- EXPORTING, CONVERT: {1, hold, 1}
- SHOW_SAVED: {2, converted value, 1}
- SHOW_FAIL: {3, hold, 1}
- IDLE with camera_detected=0: {0, hold, 1}
- IDLE with camera_detected=1: {hold, hold, 0}
REQ-017 SHALL load the output registers from that tuple only on the clock edge at which the frame edge is detected, so the display never changes mid-frame.
REQ-018 SHALL go IDLE->EXPORTING on export_start.
REQ-019 SHALL go from EXPORTING on export_done: capture save_index, clamp values >99 to 99, then enter CONVERT.
REQ-020 SHALL go EXPORTING->SHOW_FAIL on export_fail; if export_fail and export_done arrive on the same cycle, fail wins.
REQ-021 SHALL perform binary-to-BCD conversion in CONVERT by sequential shift-add-3 (double dabble), one bit per clock, 7 clocks.
REQ-022 SHALL, after CONVERT completes, write the result to an internal BCD register and enter SHOW_SAVED on the following clock, 8 clocks after export_done.
REQ-023 SHALL clear the frame counter on entry to SHOW_SAVED and SHOW_FAIL, and increment it on each frame edge.
REQ-024 SHALL return to IDLE on the frame edge at which the counter reaches MESSAGE_FRAMES-1.
REQ-025 SHALL restart on export_start in SHOW_SAVED or SHOW_FAIL: enter EXPORTING and clear the counter.
REQ-026 SHALL ignore export_start in EXPORTING and CONVERT.
REQ-027 SHALL ignore export_done and export_fail outside EXPORTING.
REQ-028 SHALL give camera_detected=0 no effect outside IDLE, because export messages take priority.
REQ-029 SHALL keep the counter at least 8 bits wide and saturate it, never wrapping.
REQ-030 SHALL drive busy combinationally from state, with no frame alignment.

Reset
REQ-031 SHALL, on reset_n=0, force asynchronously: state IDLE, string_index 0, save_index_bcd 8'h00, ui_visible 0, counter 0, and the vsync history register 0.
REQ-032 SHALL abandon any pending export or message when reset is asserted mid-operation; no output glitches toward a non-reset value while reset_n=0.
REQ-033 SHALL, after reset release with camera_detected=0, show {0, 00, 1} from the first frame edge.

Verification
REQ-034 SHALL cover: camera_detected=0, then a vsync rise -> string_index=0, ui_visible=1 on the edge-detect clock, and unchanged before it.
REQ-035 SHALL cover: export_start, then export_done with save_index=47 -> busy stays high, and after 8 clocks plus the next frame edge, string_index=2 and save_index_bcd=8'h47; after MESSAGE_FRAMES frame edges, ui_visible=0 and busy=0.
REQ-036 SHALL cover: save_index=120 on export_done -> save_index_bcd=8'h99; save_index=0 -> 8'h00; save_index=9 -> 8'h09.
REQ-037 SHALL cover: export_done and export_fail pulsed on the same cycle -> string_index=3 at the next frame edge, with save_index_bcd unchanged.
REQ-038 SHALL cover: export_start during SHOW_SAVED at frame 50 -> string_index=1 at the next frame edge, with the counter restarted by the following message.
REQ-039 SHALL cover: reset_n pulsed low during CONVERT -> all outputs at reset values immediately; the next export_done without export_start is ignored.
